// File: rtl/syn_sys_mem_arb_pkg.sv
// Shared types and helpers for the system-memory arbiter.
// The command struct is sized for the widest supported configuration; the
// top module only uses the low ADDR_W / DATA_W bits of each field.
package syn_sys_mem_arb_pkg;

    localparam int unsigned MAX_AGENTS     = 16;
    localparam int unsigned PTR_W          = 4;
    localparam int unsigned CMD_ADDR_MAX_W = 64;
    localparam int unsigned CMD_DATA_MAX_W = 256;

    typedef struct packed {
        logic                      wren;
        logic                      rden;
        logic [CMD_ADDR_MAX_W-1:0] addr;
        logic [CMD_DATA_MAX_W-1:0] wdata;
    } cmd_t;

    // One-hot round-robin grant: search starts at ptr+1 and wraps modulo n.
    // Passing ptr = n-1 turns this into a fixed lowest-index-first search.
    function automatic logic [MAX_AGENTS-1:0] next_rr_grant(
        input logic [MAX_AGENTS-1:0] req_vec,
        input logic [PTR_W-1:0]      ptr,
        input int unsigned           n
    );
        logic [MAX_AGENTS-1:0] gnt;
        logic                  found;
        logic [PTR_W-1:0]      idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_AGENTS; i++) begin
            idx = PTR_W'((32'(ptr) + i) % n);
            if ((i <= n) && !found && req_vec[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/syn_sys_mem_arb_tag_fifo.sv
// Read-tag FIFO: remembers which agent issued each outstanding read so
// returns can be routed in order.
module syn_sys_mem_arb_tag_fifo #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_id,
    input  logic            i_pop,
    output logic            o_full,
    output logic            o_empty,
    output logic [ID_W-1:0] o_rd_id
);
    import syn_sys_mem_arb_pkg::*;

    localparam int P_W = $clog2(DEPTH);
    localparam int C_W = P_W + 1;

    logic [ID_W-1:0] r_mem [DEPTH];
    logic [P_W-1:0]  r_wr_ptr;
    logic [P_W-1:0]  r_rd_ptr;
    logic [C_W-1:0]  r_cnt;

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_id;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + P_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + P_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + C_W'(1);
                2'b01:   r_cnt <= r_cnt - C_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_full  = (r_cnt == C_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_rd_id = r_mem[r_rd_ptr];

endmodule

// File: rtl/syn_sys_mem_arb.sv
// N-agent arbiter in front of the single sys_mem controller port.
// Round-robin grant into one registered command slot, read responses routed
// back in order through a tag FIFO.
// Build option: define SYS_MEM_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no pointer register).
module syn_sys_mem_arb #(
    parameter int NUM_AGENTS   = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 27,
    parameter int RD_TAG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_AGENTS-1:0]        agent_wren,
    input  logic [NUM_AGENTS-1:0]        agent_rden,
    input  logic [NUM_AGENTS*ADDR_W-1:0] agent_addr,
    input  logic [NUM_AGENTS*DATA_W-1:0] agent_wdata,
    output logic [NUM_AGENTS-1:0]        agent_rdy,
    output logic [NUM_AGENTS-1:0]        agent_rd_valid,
    output logic [DATA_W-1:0]            agent_rdata,
    input  logic                         cntrlr_rdy,
    output logic                         cntrlr_wren,
    output logic                         cntrlr_rden,
    output logic [ADDR_W-1:0]            cntrlr_addr,
    output logic [DATA_W-1:0]            cntrlr_wdata,
    input  logic                         cntrlr_rd_valid,
    input  logic [DATA_W-1:0]            cntrlr_rdata,
    output logic                         rd_err
);
    import syn_sys_mem_arb_pkg::*;

    localparam int ID_W = $clog2(NUM_AGENTS);

    cmd_t                  r_cmd;
    logic [NUM_AGENTS-1:0] r_rd_valid;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rd_err;

    logic [NUM_AGENTS-1:0] w_elig;
    logic [NUM_AGENTS-1:0] w_grant;
    logic [MAX_AGENTS-1:0] w_gnt_full;
    logic [NUM_AGENTS-1:0] w_rd_onehot;
    logic [ID_W-1:0]       w_ptr;
    logic [ID_W-1:0]       w_gid;
    logic [ID_W-1:0]       w_rd_id;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_slot_full;
    logic                  w_can_load;
    logic                  w_g_wr;
    logic                  w_g_rd;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_unused_ok;

    // The slot may reload when empty or when its command is consumed now.
    // A full tag FIFO blocks read-only requesters even if it pops this cycle.
    assign w_slot_full = r_cmd.wren | r_cmd.rden;
    assign w_can_load  = ~w_slot_full | cntrlr_rdy;
    assign w_elig      = agent_wren | (agent_rden & {NUM_AGENTS{~w_fifo_full}});
    assign w_gnt_full  = next_rr_grant(MAX_AGENTS'(w_elig), PTR_W'(w_ptr), NUM_AGENTS);
    assign w_grant     = w_can_load ? w_gnt_full[NUM_AGENTS-1:0] : '0;
    assign agent_rdy   = w_grant;

    // A combined write+read request issues only the write.
    assign w_g_wr = |(w_grant & agent_wren);
    assign w_g_rd = (|(w_grant & agent_rden)) & ~w_g_wr;
    assign w_pop  = cntrlr_rd_valid & ~w_fifo_empty;

    // Mux the granted agent's address/data and decode the returning tag.
    always_comb begin
        w_gid       = '0;
        w_addr      = '0;
        w_wdata     = '0;
        w_rd_onehot = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            if (w_grant[i]) begin
                w_gid   = ID_W'(i);
                w_addr  = agent_addr[i*ADDR_W +: ADDR_W];
                w_wdata = agent_wdata[i*DATA_W +: DATA_W];
            end
            if (w_rd_id == ID_W'(i)) w_rd_onehot[i] = 1'b1;
        end
    end

`ifdef SYS_MEM_ARB_FIXED_PRIO_EN
    assign w_ptr = ID_W'(NUM_AGENTS - 1);
`else
    logic [ID_W-1:0] r_ptr;

    // Round-robin pointer tracks the last granted agent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ptr <= ID_W'(NUM_AGENTS - 1);
        else if (|w_grant)  r_ptr <= w_gid;
    end

    assign w_ptr = r_ptr;
`endif

    // Command slot: loads the winner, or empties when consumed with no winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= '0;
        end else if (w_can_load) begin
            r_cmd.wren <= w_g_wr;
            r_cmd.rden <= w_g_rd;
            if (|w_grant) begin
                r_cmd.addr  <= CMD_ADDR_MAX_W'(w_addr);
                r_cmd.wdata <= CMD_DATA_MAX_W'(w_wdata);
            end
        end
    end

    // Read-response routing; rdata holds between returns, rd_err is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= '0;
            r_rdata    <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= w_pop ? w_rd_onehot : '0;
            if (w_pop) r_rdata <= cntrlr_rdata;
            if (cntrlr_rd_valid && w_fifo_empty) r_rd_err <= 1'b1;
        end
    end

    syn_sys_mem_arb_tag_fifo #(
        .ID_W  (ID_W),
        .DEPTH (RD_TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_g_rd),
        .i_id    (w_gid),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_rd_id (w_rd_id)
    );

    assign cntrlr_wren    = r_cmd.wren;
    assign cntrlr_rden    = r_cmd.rden;
    assign cntrlr_addr    = r_cmd.addr[ADDR_W-1:0];
    assign cntrlr_wdata   = r_cmd.wdata[DATA_W-1:0];
    assign agent_rd_valid = r_rd_valid;
    assign agent_rdata    = r_rdata;
    assign rd_err         = r_rd_err;

    // Upper struct bits and grant bits beyond NUM_AGENTS are intentionally unused.
    assign w_unused_ok = ^{w_gnt_full, r_cmd};

endmodule

// File: tb/tb_syn_sys_mem_arb.sv
// Directed testbench for syn_sys_mem_arb (4 agents, 32-bit data, 27-bit address).
module tb_syn_sys_mem_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 27;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    agent_wren = '0;
    logic [N-1:0]    agent_rden = '0;
    logic [N*AW-1:0] agent_addr = '0;
    logic [N*DW-1:0] agent_wdata = '0;
    logic [N-1:0]    agent_rdy;
    logic [N-1:0]    agent_rd_valid;
    logic [DW-1:0]   agent_rdata;
    logic            cntrlr_rdy = 1'b1;
    logic            cntrlr_wren;
    logic            cntrlr_rden;
    logic [AW-1:0]   cntrlr_addr;
    logic [DW-1:0]   cntrlr_wdata;
    logic            cntrlr_rd_valid = 1'b0;
    logic [DW-1:0]   cntrlr_rdata = '0;
    logic            rd_err;

    int n_tests = 0;
    int n_fail  = 0;

    syn_sys_mem_arb #(.NUM_AGENTS(N), .DATA_W(DW), .ADDR_W(AW), .RD_TAG_DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .agent_wren      (agent_wren),
        .agent_rden      (agent_rden),
        .agent_addr      (agent_addr),
        .agent_wdata     (agent_wdata),
        .agent_rdy       (agent_rdy),
        .agent_rd_valid  (agent_rd_valid),
        .agent_rdata     (agent_rdata),
        .cntrlr_rdy      (cntrlr_rdy),
        .cntrlr_wren     (cntrlr_wren),
        .cntrlr_rden     (cntrlr_rden),
        .cntrlr_addr     (cntrlr_addr),
        .cntrlr_wdata    (cntrlr_wdata),
        .cntrlr_rd_valid (cntrlr_rd_valid),
        .cntrlr_rdata    (cntrlr_rdata),
        .rd_err          (rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_agent(input int i, input logic wr, input logic rd,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        agent_wren[i] = wr;
        agent_rden[i] = rd;
        agent_addr[i*AW +: AW] = a;
        agent_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        agent_wren = '0;
        agent_rden = '0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (agent_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy got %b want 0000", agent_rdy); end
        n_tests++; if (agent_rd_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0000", agent_rd_valid); end
        n_tests++; if ({cntrlr_wren, cntrlr_rden} !== 2'b00) begin n_fail++; $display("FAIL reset_cmd got %b want 00", {cntrlr_wren, cntrlr_rden}); end
        n_tests++; if ({cntrlr_addr, cntrlr_wdata, agent_rdata} !== '0) begin n_fail++; $display("FAIL reset_data got %h/%h/%h want 0", cntrlr_addr, cntrlr_wdata, agent_rdata); end
        n_tests++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        set_agent(2, 1'b1, 1'b0, 27'h0000123, 32'hDEADBEEF);
        #1;
        n_tests++; if (agent_rdy !== 4'b0100) begin n_fail++; $display("FAIL wr_rdy got %b want 0100", agent_rdy); end
        tick();
        clear_all();
        n_tests++; if ({cntrlr_wren, cntrlr_rden} !== 2'b10) begin n_fail++; $display("FAIL wr_cmd got %b want 10", {cntrlr_wren, cntrlr_rden}); end
        n_tests++; if (cntrlr_addr !== 27'h0000123 || cntrlr_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_addr_data got %h/%h want 0000123/deadbeef", cntrlr_addr, cntrlr_wdata); end
        set_agent(2, 1'b0, 1'b1, 27'h0000123, 32'h0);
        #1;
        n_tests++; if (agent_rdy !== 4'b0100) begin n_fail++; $display("FAIL rd_rdy got %b want 0100", agent_rdy); end
        tick();
        clear_all();
        n_tests++; if ({cntrlr_wren, cntrlr_rden} !== 2'b01) begin n_fail++; $display("FAIL rd_cmd got %b want 01", {cntrlr_wren, cntrlr_rden}); end
        tick();
        n_tests++; if ({cntrlr_wren, cntrlr_rden} !== 2'b00) begin n_fail++; $display("FAIL slot_drain got %b want 00", {cntrlr_wren, cntrlr_rden}); end
        tick();
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata    = 32'hDEADBEEF;
        tick();
        cntrlr_rd_valid = 1'b0;
        n_tests++; if (agent_rd_valid !== 4'b0100 || agent_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_return got %b/%h want 0100/deadbeef", agent_rd_valid, agent_rdata); end
        tick();
        n_tests++; if (agent_rd_valid !== 4'b0000 || agent_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold got %b/%h want 0000/deadbeef", agent_rd_valid, agent_rdata); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < N; i++) set_agent(i, 1'b1, 1'b0, AW'(i), 32'h1000_0000 + i);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_tests++; if (agent_rdy !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_grant_%0d got %b want %b", k, agent_rdy, 4'(1 << (k % 4))); end
            tick();
            n_tests++; if (cntrlr_wren !== 1'b1 || cntrlr_addr !== AW'(k % 4)) begin n_fail++; $display("FAIL rr_issue_%0d got wren=%b addr=%h want 1/%h", k, cntrlr_wren, cntrlr_addr, k % 4); end
        end
    endtask

    task automatic test_backpressure();
        cntrlr_rdy = 1'b0;
        clear_all();
        set_agent(0, 1'b1, 1'b0, 27'h55, 32'h0000A5A5);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++; if (agent_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy_%0d got %b want 0000", k, agent_rdy); end
            tick();
            n_tests++; if (cntrlr_wren !== 1'b1 || cntrlr_addr !== 27'h3 || cntrlr_wdata !== 32'h10000003) begin n_fail++; $display("FAIL bp_hold_%0d got %b/%h/%h want 1/0000003/10000003", k, cntrlr_wren, cntrlr_addr, cntrlr_wdata); end
        end
        cntrlr_rdy = 1'b1;
        #1;
        n_tests++; if (agent_rdy !== 4'b0001) begin n_fail++; $display("FAIL bp_release_rdy got %b want 0001", agent_rdy); end
        tick();
        clear_all();
        n_tests++; if (cntrlr_wren !== 1'b1 || cntrlr_addr !== 27'h55 || cntrlr_wdata !== 32'h0000A5A5) begin n_fail++; $display("FAIL bp_release_cmd got %b/%h/%h want 1/0000055/0000a5a5", cntrlr_wren, cntrlr_addr, cntrlr_wdata); end
        tick();
    endtask

    task automatic test_tag_full();
        set_agent(1, 1'b0, 1'b1, 27'h200, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_tests++; if (agent_rdy !== 4'b0010) begin n_fail++; $display("FAIL tf_read_%0d got %b want 0010", k, agent_rdy); end
            tick();
        end
        set_agent(3, 1'b1, 1'b0, 27'h333, 32'h33333333);
        #1;
        n_tests++; if (agent_rdy !== 4'b1000) begin n_fail++; $display("FAIL tf_blocked got %b want 1000", agent_rdy); end
        tick();
        set_agent(3, 1'b0, 1'b0, 27'h333, 32'h33333333);
        n_tests++; if (cntrlr_wren !== 1'b1 || cntrlr_addr !== 27'h333) begin n_fail++; $display("FAIL tf_write got %b/%h want 1/0000333", cntrlr_wren, cntrlr_addr); end
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata    = 32'h11;
        #1;
        n_tests++; if (agent_rdy !== 4'b0000) begin n_fail++; $display("FAIL tf_full_pop got %b want 0000", agent_rdy); end
        tick();
        cntrlr_rd_valid = 1'b0;
        #1;
        n_tests++; if (agent_rd_valid !== 4'b0010 || agent_rdata !== 32'h11) begin n_fail++; $display("FAIL tf_return got %b/%h want 0010/00000011", agent_rd_valid, agent_rdata); end
        n_tests++; if (agent_rdy !== 4'b0010) begin n_fail++; $display("FAIL tf_unblock got %b want 0010", agent_rdy); end
        clear_all();
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata    = 32'h22;
        repeat (7) tick();
        cntrlr_rd_valid = 1'b0;
        n_tests++; if (agent_rd_valid !== 4'b0010 || rd_err !== 1'b0) begin n_fail++; $display("FAIL tf_drain got %b/err=%b want 0010/0", agent_rd_valid, rd_err); end
        tick();
    endtask

    task automatic test_interleaved();
        set_agent(3, 1'b0, 1'b1, 27'h300, 32'h0);
        #1;
        n_tests++; if (agent_rdy !== 4'b1000) begin n_fail++; $display("FAIL il_rdy3 got %b want 1000", agent_rdy); end
        tick();
        clear_all();
        set_agent(0, 1'b0, 1'b1, 27'h000, 32'h0);
        #1;
        n_tests++; if (agent_rdy !== 4'b0001) begin n_fail++; $display("FAIL il_rdy0 got %b want 0001", agent_rdy); end
        tick();
        clear_all();
        set_agent(2, 1'b0, 1'b1, 27'h200, 32'h0);
        #1;
        n_tests++; if (agent_rdy !== 4'b0100) begin n_fail++; $display("FAIL il_rdy2 got %b want 0100", agent_rdy); end
        tick();
        clear_all();
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata    = 32'hA3;
        tick();
        n_tests++; if (agent_rd_valid !== 4'b1000 || agent_rdata !== 32'hA3) begin n_fail++; $display("FAIL il_ret3 got %b/%h want 1000/000000a3", agent_rd_valid, agent_rdata); end
        cntrlr_rdata = 32'hA0;
        tick();
        n_tests++; if (agent_rd_valid !== 4'b0001 || agent_rdata !== 32'hA0) begin n_fail++; $display("FAIL il_ret0 got %b/%h want 0001/000000a0", agent_rd_valid, agent_rdata); end
        cntrlr_rdata = 32'hA2;
        tick();
        cntrlr_rd_valid = 1'b0;
        n_tests++; if (agent_rd_valid !== 4'b0100 || agent_rdata !== 32'hA2) begin n_fail++; $display("FAIL il_ret2 got %b/%h want 0100/000000a2", agent_rd_valid, agent_rdata); end
        tick();
        n_tests++; if (agent_rd_valid !== 4'b0000) begin n_fail++; $display("FAIL il_idle got %b want 0000", agent_rd_valid); end
    endtask

    task automatic test_rd_err();
        n_tests++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b want 0", rd_err); end
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata    = 32'hBAD;
        tick();
        cntrlr_rd_valid = 1'b0;
        n_tests++; if (agent_rd_valid !== 4'b0000 || rd_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b/err=%b want 0000/1", agent_rd_valid, rd_err); end
        n_tests++; if (agent_rdata !== 32'hA2) begin n_fail++; $display("FAIL err_rdata_hold got %h want 000000a2", agent_rdata); end
        tick();
        n_tests++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", rd_err); end
    endtask

    task automatic test_both_wr_rd();
        set_agent(0, 1'b1, 1'b1, 27'h40, 32'hCAFE);
        #1;
        n_tests++; if (agent_rdy !== 4'b0001) begin n_fail++; $display("FAIL both_rdy got %b want 0001", agent_rdy); end
        tick();
        clear_all();
        n_tests++; if ({cntrlr_wren, cntrlr_rden} !== 2'b10 || cntrlr_wdata !== 32'hCAFE) begin n_fail++; $display("FAIL both_cmd got %b/%h want 10/0000cafe", {cntrlr_wren, cntrlr_rden}, cntrlr_wdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_agent(1, 1'b0, 1'b1, 27'h77, 32'h0);
        #1;
        n_tests++; if (agent_rdy !== 4'b0010) begin n_fail++; $display("FAIL rm_read got %b want 0010", agent_rdy); end
        tick();
        clear_all();
        for (int i = 0; i < N; i++) set_agent(i, 1'b1, 1'b0, AW'(i + 8), 32'h5000_0000 + i);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        clear_all();
        #1;
        n_tests++; if ({cntrlr_wren, cntrlr_rden, agent_rdy, agent_rd_valid, rd_err} !== '0) begin n_fail++; $display("FAIL rm_ctrl got %b%b/%b/%b/%b want all 0", cntrlr_wren, cntrlr_rden, agent_rdy, agent_rd_valid, rd_err); end
        n_tests++; if ({cntrlr_addr, cntrlr_wdata, agent_rdata} !== '0) begin n_fail++; $display("FAIL rm_data got %h/%h/%h want 0", cntrlr_addr, cntrlr_wdata, agent_rdata); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        cntrlr_rd_valid = 1'b1;
        cntrlr_rdata    = 32'h77;
        tick();
        cntrlr_rd_valid = 1'b0;
        n_tests++; if (agent_rd_valid !== 4'b0000 || rd_err !== 1'b1) begin n_fail++; $display("FAIL rm_stale_return got %b/err=%b want 0000/1", agent_rd_valid, rd_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_backpressure();
        test_tag_full();
        test_interleaved();
        test_rd_err();
        test_both_wr_rd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_sys_mem_arb.md
Name: syn_sys_mem_arb

Overview:
- N-agent arbiter that multiplexes cortex-internal system-memory requesters onto the single sys_mem_cntrlr port (rdy/wren/rden/addr/wdata/rd_valid/rdata).
- Generalises the current single-master sys_mem hookup to a parametrised agent count, with round-robin grant and in-order read-response routing via a tag FIFO.
- Sits in the cntrlr_clk domain, between the cortex sub-blocks and the memory controller.

Parameters:
- NUM_AGENTS, 4, number of requesting agents (2..16).
- DATA_W, 32, memory data width.
- ADDR_W, 27, memory word-address width.
- RD_TAG_DEPTH, 8, maximum outstanding reads (power of 2).
- ID_W, $clog2(NUM_AGENTS), derived local parameter; not overridable.

Ports:
- clk  in  1  controller clock.
- rst_n  in  1  asynchronous active-low reset.
- agent_wren  in  NUM_AGENTS  per-agent write request.
- agent_rden  in  NUM_AGENTS  per-agent read request.
- agent_addr  in  NUM_AGENTS*ADDR_W  packed addresses; agent i occupies slice i.
- agent_wdata  in  NUM_AGENTS*DATA_W  packed write data.
- agent_rdy  out  NUM_AGENTS  request accepted this cycle, one-hot or zero.
- agent_rd_valid  out  NUM_AGENTS  read data valid for agent i.
- agent_rdata  out  DATA_W  shared read data bus.
- cntrlr_rdy  in  1  controller can accept a command.
- cntrlr_wren  out  1  write command.
- cntrlr_rden  out  1  read command.
- cntrlr_addr  out  ADDR_W  command address.
- cntrlr_wdata  out  DATA_W  command write data.
- cntrlr_rd_valid  in  1  read return strobe.
- cntrlr_rdata  in  DATA_W  read return data.
- rd_err  out  1  sticky: read return arrived with no read outstanding.

Behaviour:
- Reset values: all outputs 0; round-robin pointer set so that agent 0 has the highest priority; tag FIFO empty.
- Agent handshake: the agent holds wren/rden, addr and wdata until it sees agent_rdy high in the same cycle. agent_rdy is combinational from the request vector and the internal state.
- Command stage:
  - One registered command slot drives the cntrlr_* outputs.
  - The slot can load when it is empty, or when cntrlr_rdy=1, since the current command is consumed that cycle.
  - While cntrlr_rdy=0 with the slot full, all cntrlr_* outputs hold and no agent_rdy is asserted.
- Latency: an agent accepted in cycle N appears on cntrlr_wren/rden in cycle N+1.
- Eligibility:
  - An agent is eligible if it asserts wren or rden.
  - A read-only requester is ineligible while the tag FIFO is full. Full blocks new reads even if a pop occurs the same cycle.
- Arbitration:
  - Round-robin among eligible agents, starting at pointer+1.
  - On grant to agent g, the pointer becomes g.
  - No grant leaves the pointer unchanged.
- Both wren and rden from one agent: the write is issued and rdy is given. The read is not issued; the agent must re-request.
- Read tagging:
  - On a read grant, agent ID is pushed into the tag FIFO.
  - On cntrlr_rd_valid, the FIFO pops. In cycle +1, agent_rd_valid[id]=1 and agent_rdata=cntrlr_rdata (registered).
  - agent_rdata holds its last value when not valid.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- rd_valid with the FIFO empty: no agent_rd_valid is asserted and rd_err is set; it clears only on reset.
- Tag FIFO pointers wrap modulo RD_TAG_DEPTH. Occupancy counter is $clog2(RD_TAG_DEPTH)+1 bits.
- Reset mid-operation: the command slot and tags are discarded and all outputs return to 0 asynchronously. Returns arriving after reset with the FIFO empty set rd_err.

Optional Feature:
- Macro: SYS_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer register is removed and all other behaviour is identical.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package syn_sys_mem_arb_pkg holds:
  - the command struct {wren, rden, addr, wdata};
  - a function next_rr_grant(req_vec, ptr) returning a one-hot grant.
- Sub-module syn_sys_mem_arb_tag_fifo: ID_W-wide, RD_TAG_DEPTH-deep synchronous FIFO with push, pop, full, empty and rd_id outputs.

Test Plan:
- Single write, then single read:
  - Stimulus: agent 2 writes addr 0x0000123, data 0xDEADBEEF; then agent 2 reads; controller returns 0xDEADBEEF two cycles later.
  - Response: cntrlr_wren asserts one cycle after agent_rdy[2]; agent_rd_valid=4'b0100 with rdata 0xDEADBEEF one cycle after cntrlr_rd_valid.
- Round-robin:
  - Stimulus: all 4 agents request writes continuously, cntrlr_rdy=1.
  - Response: grant order 0,1,2,3,0,1,… with no idle cycles on cntrlr_wren.
- Backpressure:
  - Stimulus: cntrlr_rdy=0 for 5 cycles with the slot full.
  - Response: cntrlr_addr/wdata stable and agent_rdy=0 throughout; pending grant issues the cycle rdy returns.
- Tag-full:
  - Stimulus: agent 1 issues 8 reads with no returns.
  - Response: 9th read held off (agent_rdy[1]=0) while a concurrent agent 3 write is still accepted; first return unblocks it.
- Interleaved returns:
  - Stimulus: reads from agents 3,0,2 in that order.
  - Response: agent_rd_valid pulses 1000, 0001, 0100 in that order.
- Error and reset:
  - Stimulus: cntrlr_rd_valid with no outstanding reads.
  - Response: rd_err=1 and no agent_rd_valid.
  - Stimulus: rst_n pulsed low mid-burst.
  - Response: all outputs 0, rd_err cleared.
